// File: rtl/frame_source.sv
// Video frame source: generates sync/DE timing and streams pixels from a FIFO or
// built-in colour bars into the image-processing chain.
module frame_source #(
    parameter int unsigned H_SYNC  = 41,
    parameter int unsigned H_BACK  = 2,
    parameter int unsigned H_DISP  = 480,
    parameter int unsigned H_FRONT = 2,
    parameter int unsigned V_SYNC  = 10,
    parameter int unsigned V_BACK  = 2,
    parameter int unsigned V_DISP  = 272,
    parameter int unsigned V_FRONT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        pattern_en,
    output logic        fifo_rd_req,
    input  logic [15:0] fifo_rd_data,
    input  logic        fifo_empty,
    output logic        frame_vsync,
    output logic        frame_hsync,
    output logic        frame_de,
    output logic [15:0] rgb,
    output logic [10:0] xpos,
    output logic [10:0] ypos,
    output logic [10:0] h_disp,
    output logic [10:0] v_disp,
    output logic        frame_done,
    output logic        underflow
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

    localparam logic [10:0] H_TOT_M1    = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_TOT_M1    = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_SYNC_END  = 11'(H_SYNC);
    localparam logic [10:0] V_SYNC_END  = 11'(V_SYNC);
    localparam logic [10:0] H_ACT_START = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] V_ACT_START = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] H_ACT_END   = 11'(H_SYNC + H_BACK + H_DISP);
    localparam logic [10:0] V_ACT_END   = 11'(V_SYNC + V_BACK + V_DISP);
    localparam logic [10:0] H_ACT_LAST  = 11'(H_SYNC + H_BACK + H_DISP - 1);
    localparam logic [10:0] V_ACT_LAST  = 11'(V_SYNC + V_BACK + V_DISP - 1);
    localparam logic [10:0] BAR_W_M1    = 11'((H_DISP >> 3) - 1);

    logic [10:0] h_cnt_q, v_cnt_q;
    logic        pattern_q;
    logic [10:0] bar_cnt_q;
    logic [2:0]  bar_idx_q;
    logic        hsync_q, vsync_q, de_q, done_q, grant_q, underflow_q;
    logic [10:0] xpos_q, ypos_q;
    logic [15:0] bar_rgb_q;

    logic        h_act, v_act, pre_de;
    logic [15:0] bar_color;

    assign h_act       = (h_cnt_q >= H_ACT_START) && (h_cnt_q < H_ACT_END);
    assign v_act       = (v_cnt_q >= V_ACT_START) && (v_cnt_q < V_ACT_END);
    assign pre_de      = enable & h_act & v_act;
    assign fifo_rd_req = pre_de & ~pattern_q & ~fifo_empty;

    always_comb begin
        bar_color = 16'h0000;
        case (bar_idx_q)
            3'd0:    bar_color = 16'hFFFF;
            3'd1:    bar_color = 16'hFFE0;
            3'd2:    bar_color = 16'h07FF;
            3'd3:    bar_color = 16'h07E0;
            3'd4:    bar_color = 16'hF81F;
            3'd5:    bar_color = 16'hF800;
            3'd6:    bar_color = 16'h001F;
            default: bar_color = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            pattern_q   <= 1'b0;
            bar_cnt_q   <= '0;
            bar_idx_q   <= '0;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            de_q        <= 1'b0;
            done_q      <= 1'b0;
            grant_q     <= 1'b0;
            underflow_q <= 1'b0;
            xpos_q      <= '0;
            ypos_q      <= '0;
            bar_rgb_q   <= '0;
        end else if (!enable) begin
            // Idle: park at frame start so the next enable begins a full frame.
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
            hsync_q   <= 1'b0;
            vsync_q   <= 1'b0;
            de_q      <= 1'b0;
            done_q    <= 1'b0;
            grant_q   <= 1'b0;
            xpos_q    <= '0;
            ypos_q    <= '0;
            bar_rgb_q <= '0;
        end else begin
            if (h_cnt_q == H_TOT_M1) begin
                h_cnt_q <= '0;
                v_cnt_q <= (v_cnt_q == V_TOT_M1) ? 11'd0 : v_cnt_q + 11'd1;
            end else begin
                h_cnt_q <= h_cnt_q + 11'd1;
            end

            if (h_cnt_q == 11'd0 && v_cnt_q == 11'd0) begin
                pattern_q <= pattern_en;
            end

            hsync_q   <= (h_cnt_q < H_SYNC_END);
            vsync_q   <= (v_cnt_q < V_SYNC_END);
            de_q      <= pre_de;
            grant_q   <= fifo_rd_req;
            done_q    <= pre_de && (h_cnt_q == H_ACT_LAST) && (v_cnt_q == V_ACT_LAST);
            xpos_q    <= pre_de ? h_cnt_q - H_ACT_START : 11'd0;
            ypos_q    <= pre_de ? v_cnt_q - V_ACT_START : 11'd0;
            bar_rgb_q <= (pre_de && pattern_q) ? bar_color : 16'h0000;

            if (pre_de && !pattern_q && fifo_empty) begin
                underflow_q <= 1'b1;
            end

            // Bar position tracks the pixel without a divider; bar 7 soaks up the remainder.
            if (!h_act) begin
                bar_cnt_q <= '0;
                bar_idx_q <= '0;
            end else if (bar_idx_q != 3'd7) begin
                if (bar_cnt_q == BAR_W_M1) begin
                    bar_cnt_q <= '0;
                    bar_idx_q <= bar_idx_q + 3'd1;
                end else begin
                    bar_cnt_q <= bar_cnt_q + 11'd1;
                end
            end
        end
    end

    // FIFO data arrives the clock after the request, so it bypasses the output register.
    assign rgb         = grant_q ? fifo_rd_data : bar_rgb_q;
    assign frame_hsync = hsync_q;
    assign frame_vsync = vsync_q;
    assign frame_de    = de_q;
    assign frame_done  = done_q;
    assign xpos        = xpos_q;
    assign ypos        = ypos_q;
    assign underflow   = underflow_q;
    assign h_disp      = 11'(H_DISP);
    assign v_disp      = 11'(V_DISP);

endmodule

// File: tb/tb_frame_source.sv
// Randomised self-checking bench for frame_source against a frame-position model.
module tb_frame_source;

    localparam int HS = 2, HB = 2, HD = 16, HF = 2;
    localparam int VS = 1, VB = 1, VD = 4, VF = 1;
    localparam int HT = HS + HB + HD + HF;
    localparam int VT = VS + VB + VD + VF;
    localparam int FRAME = HT * VT;
    localparam int BW = HD >> 3;

    logic        clk = 1'b0;
    logic        rst_n, enable, pattern_en, fifo_empty;
    logic        fifo_rd_req;
    logic [15:0] fifo_rd_data;
    logic        frame_vsync, frame_hsync, frame_de, frame_done, underflow;
    logic [15:0] rgb;
    logic [10:0] xpos, ypos, h_disp, v_disp;

    frame_source #(
        .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_en(pattern_en),
        .fifo_rd_req(fifo_rd_req), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
        .frame_vsync(frame_vsync), .frame_hsync(frame_hsync), .frame_de(frame_de),
        .rgb(rgb), .xpos(xpos), .ypos(ypos), .h_disp(h_disp), .v_disp(v_disp),
        .frame_done(frame_done), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int pos = 0, model_next = 0, fifo_cnt = 0;
    bit model_pat = 0, model_uf = 0, uf_mode = 0, rand_mode = 0;
    int hs_cnt, vs_cnt, de_cnt, done_cnt;
    logic [15:0] cap [64];
    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_stats();
        hs_cnt = 0; vs_cnt = 0; de_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 64; i++) cap[i] = 16'hDEAD;
    endtask

    // One clock: drive per-cycle inputs, predict from the frame position, compare.
    task automatic cycle();
        int h, v, x, y, bi;
        bit de_e, req_e, req_s, hs_e, vs_e, done_e;
        logic [15:0] rgb_e;
        @(negedge clk);
        if (uf_mode) fifo_empty = (pos == 4 * HT + 9);
        else if (rand_mode) begin
            fifo_empty = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 19) == 0) pattern_en = ~pattern_en;
        end
        h = pos % HT; v = pos / HT;
        x = h - (HS + HB); y = v - (VS + VB);
        de_e  = enable && h >= HS + HB && h < HS + HB + HD && v >= VS + VB && v < VS + VB + VD;
        req_e = de_e && !model_pat && !fifo_empty;
        #1;
        req_s = fifo_rd_req;
        chk("fifo_rd_req", 32'(req_s), 32'(req_e));
        hs_e = enable && h < HS;
        vs_e = enable && v < VS;
        done_e = de_e && x == HD - 1 && y == VD - 1;
        bi = (x / BW > 7) ? 7 : x / BW;
        if (!de_e) rgb_e = 16'h0000;
        else if (model_pat) rgb_e = bars[bi];
        else if (fifo_empty) rgb_e = 16'h0000;
        else rgb_e = 16'(model_next);
        if (de_e && !model_pat && fifo_empty) model_uf = 1;
        @(posedge clk);
        #1;
        if (req_s) begin fifo_rd_data = 16'(fifo_cnt); fifo_cnt++; end
        if (req_e) model_next++;
        if (enable) begin
            if (pos == 0) model_pat = pattern_en;
            pos = (pos + 1) % FRAME;
        end else pos = 0;
        #1;
        chk("hsync", 32'(frame_hsync), 32'(hs_e));
        chk("vsync", 32'(frame_vsync), 32'(vs_e));
        chk("de", 32'(frame_de), 32'(de_e));
        chk("xpos", 32'(xpos), de_e ? 32'(x) : 32'd0);
        chk("ypos", 32'(ypos), de_e ? 32'(y) : 32'd0);
        chk("rgb", 32'(rgb), 32'(rgb_e));
        chk("frame_done", 32'(frame_done), 32'(done_e));
        chk("underflow", 32'(underflow), 32'(model_uf));
        hs_cnt += int'(frame_hsync);
        vs_cnt += int'(frame_vsync);
        de_cnt += int'(frame_de);
        done_cnt += int'(frame_done);
        if (de_e) cap[y * HD + x] = rgb;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < FRAME && pos != target; i++) cycle();
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_sync"}, {30'd0, frame_vsync, frame_hsync}, 32'd0);
        chk({name, "_de"}, {31'd0, frame_de}, 32'd0);
        chk({name, "_xy"}, {10'd0, xpos, ypos}, 32'd0);
        chk({name, "_rgb"}, {16'd0, rgb}, 32'd0);
        chk({name, "_done"}, {31'd0, frame_done}, 32'd0);
        chk({name, "_req"}, {31'd0, fifo_rd_req}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; pattern_en = 1'b0; fifo_empty = 1'b0;
        fifo_rd_data = 16'h0000;
        repeat (2) @(posedge clk);
        #2;
        chk_all_zero("reset");
        chk("reset_underflow", {31'd0, underflow}, 32'd0);
        chk("h_disp", {21'd0, h_disp}, 32'd16);
        chk("v_disp", {21'd0, v_disp}, 32'd4);

        // Frame 1: continuous FIFO data, timing and data path pinned by literals.
        enable = 1'b1; rst_n = 1'b1;
        clear_stats();
        cycle();
        chk("start_vs_hs", {30'd0, frame_vsync, frame_hsync}, 32'd3);
        run(FRAME - 1);
        chk("frame_hs_count", hs_cnt, 32'd14);
        chk("frame_vs_count", vs_cnt, 32'd22);
        chk("frame_de_count", de_cnt, 32'd64);
        chk("frame_done_count", done_cnt, 32'd1);
        chk("frame_reads", fifo_cnt, 32'd64);
        for (int i = 0; i < 64; i++) chk("rgb_xy", {16'd0, cap[i]}, i);
        chk("no_underflow", {31'd0, underflow}, 32'd0);

        // Underflow on pixel (5,2) only.
        clear_stats();
        uf_mode = 1;
        run(FRAME);
        uf_mode = 0; fifo_empty = 1'b0;
        chk("uf_pixel_rgb", {16'd0, cap[2 * HD + 5]}, 32'd0);
        chk("uf_set", {31'd0, underflow}, 32'd1);
        run(FRAME);
        chk("uf_sticky", {31'd0, underflow}, 32'd1);

        // Random FIFO stalls and pattern toggles.
        rand_mode = 1;
        run(3 * FRAME);
        rand_mode = 0; fifo_empty = 1'b0;

        // Colour bars, with pattern_en dropped mid-frame at ypos 2.
        pattern_en = 1'b1;
        run_to(0);
        clear_stats();
        run(4 * HT);
        pattern_en = 1'b0;
        run(FRAME - 4 * HT);
        chk("bar_x0", {16'd0, cap[0]}, 32'hFFFF);
        chk("bar_x3", {16'd0, cap[3]}, 32'hFFE0);
        chk("bar_x4", {16'd0, cap[4]}, 32'h07FF);
        chk("bar_x9", {16'd0, cap[9]}, 32'hF81F);
        chk("bar_x10", {16'd0, cap[2 * HD + 10]}, 32'hF800);
        chk("bar_x7_y3", {16'd0, cap[3 * HD + 7]}, 32'h07E0);
        chk("bar_x12_y3", {16'd0, cap[3 * HD + 12]}, 32'h001F);
        chk("bar_x14_y3", {16'd0, cap[3 * HD + 14]}, 32'h0000);
        run(FRAME);

        // Enable abort after pixel (7,1).
        run_to(3 * HT + 12);
        chk("abort_at_x", {21'd0, xpos}, 32'd7);
        chk("abort_at_y", {21'd0, ypos}, 32'd1);
        enable = 1'b0;
        cycle();
        chk_all_zero("abort");
        run(3);
        enable = 1'b1;
        cycle();
        chk("reenable_vs_hs", {30'd0, frame_vsync, frame_hsync}, 32'd3);
        clear_stats();
        run(FRAME);
        chk("reenable_done_count", done_cnt, 32'd1);

        // Asynchronous reset mid-frame at ypos 3.
        run_to(5 * HT + 8);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        chk("async_rst_underflow", {31'd0, underflow}, 32'd0);
        pos = 0; model_pat = 0; model_uf = 0; model_next = 0; fifo_cnt = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        clear_stats();
        cycle();
        chk("rst_restart_vs_hs", {30'd0, frame_vsync, frame_hsync}, 32'd3);
        run(FRAME - 1);
        chk("rst_frame_reads", fifo_cnt, 32'd64);
        chk("rst_frame_done", done_cnt, 32'd1);
        chk("rst_rgb_first", {16'd0, cap[0]}, 32'd0);
        chk("rst_rgb_last", {16'd0, cap[63]}, 32'd63);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
